// File: rtl/mycpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mycpu_pkg
//  Description : Shared types for the MEM pipeline stage. Holds the bus
//                widths, bus layouts, exception and memop bit orders, and the
//                FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mycpu_pkg;

    // Bus widths
    localparam int ES_TO_MS_BUS_WD = 165;
    localparam int MS_TO_WS_BUS_WD = 155;
    localparam int MS_RES          = 43;

    // The MSB of cp0_msg flags an instruction whose result comes from CP0 (mfc0)
    localparam int CP0_RES_BIT = 41;

    // Exception vector, MSB first: int,ri,bp,ov,ades,adel,sys = 6..0
    typedef struct packed {
        logic intr;
        logic ri;
        logic bp;
        logic ov;
        logic ades;
        logic adel;
        logic sys;
    } exc_t;

    // Memory operation one-hot, MSB first: lwr,lwl,hu,h,bu,b,w = 6..0
    typedef struct packed {
        logic lwr;
        logic lwl;
        logic hu;
        logic h;
        logic bu;
        logic b;
        logic w;
    } memop_t;

    // EXE -> MEM bus layout
    typedef struct packed {
        logic        delay_slot;
        logic [41:0] cp0_msg;
        exc_t        exc;
        logic [1:0]  addr_low2b;
        memop_t      memop_type;
        logic [31:0] badvaddr;
        logic        res_from_mem;
        logic [3:0]  gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    // MEM -> WB bus layout
    typedef struct packed {
        logic        delay_slot;
        logic [41:0] cp0_msg;
        exc_t        exc;
        logic [31:0] badvaddr;
        logic [3:0]  gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    // MEM forwarding bundle to decode
    typedef struct packed {
        logic        res_from_cp0;
        logic        load_pending;
        logic [3:0]  gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } ms_res_t;

    // Data-access FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Interface   : mem_stage_if
//  Description : Handshake and bus bundle around the MEM stage. The master
//                side is the surrounding pipeline (EXE, WB, data SRAM); the
//                slave side is mem_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int EXC_W  = 7
);
    import mycpu_pkg::*;

    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       es_req_sent;
    logic [DATA_W-1:0]          data_sram_rdata;
    logic                       data_sram_dataok;
    logic [EXC_W-1:0]           wbexc;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_RES-1:0]          ms_res;
    logic [EXC_W-1:0]           memexc;

    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus, es_req_sent,
               data_sram_rdata, data_sram_dataok, wbexc,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_res, memexc
    );

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus, es_req_sent,
               data_sram_rdata, data_sram_dataok, wbexc,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_res, memexc
    );

endinterface
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load-data alignment and extension. Produces
//                the register write data and the refined byte strobe used by
//                lwl/lwr partial writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mycpu_pkg::*;
(
    input  wire logic [31:0] rdata_i,
    input  memop_t           memop_i,
    input  wire logic [1:0]  addr_low2b_i,
    input  wire logic [3:0]  gr_we_i,
    output logic      [31:0] data_o,
    output logic      [3:0]  strobe_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_shl;
    logic [4:0]  w_shr;

    // Select the addressed byte/halfword and build extended or shifted data
    always_comb begin
        w_byte   = rdata_i[{addr_low2b_i, 3'b000} +: 8];
        w_half   = addr_low2b_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        // lwl shifts left by 3-a bytes; for a 2-bit value 3-a equals ~a
        w_shl    = {~addr_low2b_i, 3'b000};
        w_shr    = {addr_low2b_i, 3'b000};
        data_o   = rdata_i;
        strobe_o = gr_we_i;
        if (memop_i.b) begin
            data_o = {{24{w_byte[7]}}, w_byte};
        end else if (memop_i.bu) begin
            data_o = {24'd0, w_byte};
        end else if (memop_i.h) begin
            data_o = {{16{w_half[15]}}, w_half};
        end else if (memop_i.hu) begin
            data_o = {16'd0, w_half};
        end else if (memop_i.lwl) begin
            data_o   = rdata_i << w_shl;
            strobe_o = 4'b1111 << ~addr_low2b_i;
        end else if (memop_i.lwr) begin
            data_o   = rdata_i >> w_shr;
            strobe_o = 4'b1111 >> addr_low2b_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage between EXE and WB. Waits for the data
//                SRAM data handshake of loads/stores, aligns load data, and
//                drives the WB bus, forwarding bundle and exception vector.
//                Stale SRAM responses after a WB flush are swallowed.
//                Optional feature macro: MS_LOAD_FWD_EN (forward load data to
//                decode as soon as it is ready instead of stalling decode
//                until the load reaches WB).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mycpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EXC_W  = 7
)(
    input wire logic   clk,
    input wire logic   reset,
    mem_stage_if.slave ms_if
);

    es_to_ms_t         bus_q;
    logic              ms_valid_q;
    logic              need_data_q;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [DATA_W-1:0] rdata_buf_q;

    es_to_ms_t         es_bus;
    logic              flush;
    logic              dataok;
    logic              ms_ready_go;
    logic              accept;
    logic              accept_req;
    logic [1:0]        req_next_state;
    logic [DATA_W-1:0] rdata_sel;
    logic [31:0]       align_data;
    logic [3:0]        align_strobe;
    logic [31:0]       final_result;
    logic [3:0]        gr_we_wb;
    logic              load_pending;
    ms_to_ws_t         wb_bus;
    ms_res_t           fwd_bus;

    assign es_bus = ms_if.es_to_ms_bus;
    assign flush  = |ms_if.wbexc;
    assign dataok = ms_if.data_sram_dataok;

    // Handshake outputs: readiness, back-pressure and WB valid
    always_comb begin
        ms_ready_go = !need_data_q || (state_q == ST_HOLD) ||
                      ((state_q == ST_WAIT) && dataok);
        // While discarding, the stage stays closed until the stale response drains
        ms_if.ms_allowin = (state_q != ST_DISCARD) &&
                           (!ms_valid_q || (ms_ready_go && ms_if.ws_allowin));
        ms_if.ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
        ms_if.memexc = ms_valid_q ? EXC_W'(bus_q.exc) : '0;
        accept     = ms_if.es_to_ms_valid && ms_if.ms_allowin;
        accept_req = accept && ms_if.es_req_sent;
    end

    // Valid bit, bus register and need-data flag
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            bus_q       <= '0;
            need_data_q <= 1'b0;
        end else begin
            if (flush) begin
                ms_valid_q <= 1'b0;
            end else if (ms_if.ms_allowin) begin
                ms_valid_q <= ms_if.es_to_ms_valid;
            end
            if (accept) begin
                bus_q       <= es_bus;
                need_data_q <= ms_if.es_req_sent;
            end
        end
    end

    // Capture returned data when it cannot be passed straight to WB
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf_q <= '0;
        end else if ((state_q == ST_WAIT) && dataok) begin
            rdata_buf_q <= ms_if.data_sram_rdata;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a dataok seen alongside a new acceptance settles the old request
    always_comb begin
        // Where the FSM lands once the current access has retired
        if (accept_req) begin
            req_next_state = flush ? ST_DISCARD : ST_WAIT;
        end else begin
            req_next_state = ST_IDLE;
        end
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = req_next_state;
            end
            ST_WAIT: begin
                if (dataok) begin
                    state_d = (flush || ms_if.ws_allowin) ? req_next_state : ST_HOLD;
                end else if (flush) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (flush || ms_if.ws_allowin) begin
                    state_d = req_next_state;
                end
            end
            ST_DISCARD: begin
                if (dataok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Zero-latency path uses live SRAM data; HOLD uses the captured copy
    assign rdata_sel = (state_q == ST_HOLD) ? rdata_buf_q : ms_if.data_sram_rdata;

    load_align u_load_align (
        .rdata_i      (rdata_sel),
        .memop_i      (bus_q.memop_type),
        .addr_low2b_i (bus_q.addr_low2b),
        .gr_we_i      (bus_q.gr_we),
        .data_o       (align_data),
        .strobe_o     (align_strobe)
    );

    // Result selection and WB / forwarding bus assembly
    always_comb begin
        final_result = bus_q.res_from_mem ? align_data : bus_q.alu_result;
        // A faulting instruction must never write the register file
        if (|bus_q.exc) begin
            gr_we_wb = 4'b0000;
        end else begin
            gr_we_wb = bus_q.res_from_mem ? align_strobe : bus_q.gr_we;
        end
`ifdef MS_LOAD_FWD_EN
        load_pending = bus_q.res_from_mem && !ms_ready_go;
`else
        load_pending = bus_q.res_from_mem;
`endif
        wb_bus.delay_slot   = bus_q.delay_slot;
        wb_bus.cp0_msg      = bus_q.cp0_msg;
        wb_bus.exc          = bus_q.exc;
        wb_bus.badvaddr     = bus_q.badvaddr;
        wb_bus.gr_we        = gr_we_wb;
        wb_bus.dest         = bus_q.dest;
        wb_bus.final_result = final_result;
        wb_bus.pc           = bus_q.pc;
        fwd_bus.res_from_cp0 = bus_q.cp0_msg[CP0_RES_BIT];
        fwd_bus.load_pending = load_pending;
        fwd_bus.gr_we        = gr_we_wb;
        fwd_bus.dest         = bus_q.dest;
        fwd_bus.final_result = final_result;
        ms_if.ms_to_ws_bus = wb_bus;
        ms_if.ms_res       = ms_valid_q ? fwd_bus : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. Directed steps from the
//                test plan followed by randomized single-instruction traffic,
//                checked cycle by cycle against a byte-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage;
    import mycpu_pkg::*;

`ifdef MS_LOAD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [6:0] M_NONE = 7'b0000000;
    localparam logic [6:0] M_W    = 7'b0000001;
    localparam logic [6:0] M_B    = 7'b0000010;
    localparam logic [6:0] M_BU   = 7'b0000100;
    localparam logic [6:0] M_H    = 7'b0001000;
    localparam logic [6:0] M_LWL  = 7'b0100000;
    localparam logic [6:0] M_LWR  = 7'b1000000;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_stage_if #(.DATA_W(32), .EXC_W(7)) bus_if ();

    mem_stage #(.DATA_W(32), .EXC_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .ms_if (bus_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic es_to_ms_t mk(input logic [6:0] mop, input logic [1:0] a,
                                     input logic [31:0] alu, input logic [6:0] exc,
                                     input bit load);
        es_to_ms_t e;
        e              = '0;
        e.memop_type   = memop_t'(mop);
        e.addr_low2b   = a;
        e.alu_result   = alu;
        e.badvaddr     = alu ^ 32'h0000_0F00;
        e.exc          = exc_t'(exc);
        e.res_from_mem = load;
        e.gr_we        = 4'hF;
        e.dest         = 5'd9;
        e.pc           = 32'hBFC0_0010;
        e.cp0_msg      = 42'h0AB_CDEF_1234;
        return e;
    endfunction

    // Reference: each destination byte is picked from the loaded bytes by rule
    function automatic ms_to_ws_t model_wb(input es_to_ms_t e, input logic [31:0] rd);
        ms_to_ws_t   w;
        logic [7:0]  b [4];
        logic [7:0]  o [4];
        logic [3:0]  st;
        logic [31:0] res;
        int          a;
        int          idx;
        int          v;
        for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
        a   = int'(e.addr_low2b);
        st  = e.gr_we;
        res = rd;
        if (!e.res_from_mem) begin
            res = e.alu_result;
        end else if (e.memop_type.b || e.memop_type.bu) begin
            v = int'(b[a]);
            if (e.memop_type.b && v >= 128) v = v - 256;
            res = 32'(v);
        end else if (e.memop_type.h || e.memop_type.hu) begin
            idx = (a / 2) * 2;
            v   = int'(b[idx]) + 256 * int'(b[idx+1]);
            if (e.memop_type.h && v >= 32768) v = v - 65536;
            res = 32'(v);
        end else if (e.memop_type.lwl) begin
            for (int i = 0; i < 4; i++) begin
                o[i]  = (i >= 3 - a) ? b[i-(3-a)] : 8'h00;
                st[i] = (i >= 3 - a);
            end
            res = {o[3], o[2], o[1], o[0]};
        end else if (e.memop_type.lwr) begin
            for (int i = 0; i < 4; i++) begin
                o[i]  = (i + a <= 3) ? b[i+a] : 8'h00;
                st[i] = (i <= 3 - a);
            end
            res = {o[3], o[2], o[1], o[0]};
        end
        w.delay_slot   = e.delay_slot;
        w.cp0_msg      = e.cp0_msg;
        w.exc          = e.exc;
        w.badvaddr     = e.badvaddr;
        w.gr_we        = (e.exc != '0) ? 4'h0 : st;
        w.dest         = e.dest;
        w.final_result = res;
        w.pc           = e.pc;
        return w;
    endfunction

    // One instruction: accept, data after lat cycles, WB held off for stall cycles once ready
    task automatic do_txn(input es_to_ms_t e, input bit req, input int lat,
                          input logic [31:0] rd, input int stall, input string tag);
        ms_to_ws_t wb_exp;
        ms_res_t   res_exp;
        ms_res_t   res_obs;
        bit        got;
        bit        done;
        bit        ready;
        int        waited;
        int        cyc;
        wb_exp = model_wb(e, rd);
        bus_if.es_to_ms_valid   = 1'b1;
        bus_if.es_to_ms_bus     = e;
        bus_if.es_req_sent      = req;
        bus_if.data_sram_dataok = 1'b0;
        bus_if.ws_allowin       = 1'b1;
        bus_if.wbexc            = '0;
        #2;
        chk({tag, ":accept_allowin"}, bus_if.ms_allowin, 1'b1);
        chk({tag, ":accept_empty"}, bus_if.ms_to_ws_valid, 1'b0);
        tick();
        bus_if.es_to_ms_valid = 1'b0;
        bus_if.es_req_sent    = 1'b0;
        got = 0; done = 0; waited = 0; cyc = 0;
        while (!done && cyc < 64) begin
            cyc++;
            bus_if.data_sram_dataok = req && (cyc == lat);
            bus_if.data_sram_rdata  = bus_if.data_sram_dataok ? rd : $urandom();
            ready = !req || got || bus_if.data_sram_dataok;
            if (ready) begin
                bus_if.ws_allowin = (waited >= stall);
                waited++;
            end else begin
                bus_if.ws_allowin = 1'($urandom());
            end
            #2;
            res_obs = bus_if.ms_res;
            chk({tag, ":ms_to_ws_valid"}, bus_if.ms_to_ws_valid, ready);
            chk({tag, ":ms_allowin"}, bus_if.ms_allowin, ready && bus_if.ws_allowin);
            chk({tag, ":memexc"}, bus_if.memexc, 7'(e.exc));
            chk({tag, ":pending"}, res_obs.load_pending, e.res_from_mem && !(FWD && ready));
            if (ready && bus_if.ws_allowin) begin
                res_exp.res_from_cp0 = e.cp0_msg[41];
                res_exp.load_pending = e.res_from_mem && !FWD;
                res_exp.gr_we        = wb_exp.gr_we;
                res_exp.dest         = e.dest;
                res_exp.final_result = wb_exp.final_result;
                chk({tag, ":wb_bus"}, bus_if.ms_to_ws_bus, wb_exp);
                chk({tag, ":ms_res"}, res_obs, res_exp);
                done = 1;
            end
            if (bus_if.data_sram_dataok) got = 1;
            tick();
        end
        bus_if.data_sram_dataok = 1'b0;
        bus_if.ws_allowin       = 1'b1;
        chk({tag, ":completed"}, done, 1'b1);
    endtask

    es_to_ms_t e;
    es_to_ms_t e2;
    int        k;

    initial begin
        reset                   = 1'b1;
        bus_if.ws_allowin       = 1'b1;
        bus_if.es_to_ms_valid   = 1'b0;
        bus_if.es_to_ms_bus     = '0;
        bus_if.es_req_sent      = 1'b0;
        bus_if.data_sram_rdata  = '0;
        bus_if.data_sram_dataok = 1'b0;
        bus_if.wbexc            = '0;
        tick();
        tick();
        chk("reset:ms_to_ws_valid", bus_if.ms_to_ws_valid, 1'b0);
        chk("reset:memexc", bus_if.memexc, 7'd0);
        chk("reset:ms_res", bus_if.ms_res, 43'd0);
        chk("reset:ms_allowin", bus_if.ms_allowin, 1'b1);
        reset = 1'b0;
        tick();

        // Directed loads from the test plan
        do_txn(mk(M_W,   2'd0, 32'h100, 7'd0, 1'b1), 1'b1, 2, 32'hDEADBEEF, 0, "lw");
        do_txn(mk(M_B,   2'd3, 32'h103, 7'd0, 1'b1), 1'b1, 1, 32'h80112233, 0, "lb");
        do_txn(mk(M_BU,  2'd3, 32'h103, 7'd0, 1'b1), 1'b1, 3, 32'h80112233, 0, "lbu");
        do_txn(mk(M_H,   2'd2, 32'h102, 7'd0, 1'b1), 1'b1, 1, 32'h80112233, 0, "lh");
        do_txn(mk(M_LWL, 2'd1, 32'h101, 7'd0, 1'b1), 1'b1, 2, 32'h11223344, 0, "lwl");
        do_txn(mk(M_LWR, 2'd2, 32'h102, 7'd0, 1'b1), 1'b1, 2, 32'h11223344, 0, "lwr");
        do_txn(mk(M_W,   2'd0, 32'h104, 7'd0, 1'b1), 1'b1, 1, 32'hCAFEF00D, 3, "hold");

        // Flush while waiting: stale dataok must be swallowed
        e = mk(M_W, 2'd0, 32'h200, 7'd0, 1'b1);
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = e;
        bus_if.es_req_sent    = 1'b1;
        #2;
        chk("flush:accept", bus_if.ms_allowin, 1'b1);
        tick();
        bus_if.es_to_ms_valid = 1'b0;
        bus_if.es_req_sent    = 1'b0;
        bus_if.wbexc          = 7'b0000001;
        #2;
        chk("flush:no_valid", bus_if.ms_to_ws_valid, 1'b0);
        chk("flush:allowin", bus_if.ms_allowin, 1'b0);
        tick();
        bus_if.wbexc = '0;
        e2 = mk(M_W, 2'd0, 32'h300, 7'd0, 1'b1);
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = e2;
        bus_if.es_req_sent    = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            bus_if.data_sram_dataok = (c == 4);
            bus_if.data_sram_rdata  = (c == 4) ? 32'hBAD0BAD0 : $urandom();
            #2;
            chk("discard:allowin", bus_if.ms_allowin, 1'b0);
            chk("discard:no_valid", bus_if.ms_to_ws_valid, 1'b0);
            chk("discard:memexc", bus_if.memexc, 7'd0);
            tick();
        end
        bus_if.data_sram_dataok = 1'b0;
        do_txn(e2, 1'b1, 2, 32'h12345678, 0, "after_flush");

        // Non-memory instruction carrying an overflow exception
        e = mk(M_NONE, 2'd0, 32'h7FFF_FFFF, 7'b0001000, 1'b0);
        e.cp0_msg = 42'h200_0000_0000;
        do_txn(e, 1'b0, 1, 32'h0, 0, "add_ov");

        // Randomized single-instruction traffic
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 7);
            e = mk((k == 0) ? M_NONE : 7'(1 << (k - 1)), 2'($urandom()), $urandom(),
                   ($urandom_range(0, 5) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'd0,
                   k != 0);
            e.pc         = $urandom();
            e.dest       = 5'($urandom());
            e.delay_slot = 1'($urandom());
            e.cp0_msg    = 42'({$urandom(), $urandom()});
            do_txn(e, k != 0, $urandom_range(1, 4), $urandom(), $urandom_range(0, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
